lpc_port_capture: RTL and testbench

Passive LPC bus snooper that decodes host I/O write cycles to one configured port (default 0x3F8), buffers captured bytes in a small FIFO, and feeds them one at a time to the downstream `uart` transmitter over its `data`/`data_valid`/`busy` interface. It sits directly upstream of `uart`, shares its 33 MHz LPC clock, and never drives LAD.

---
 rtl/lpc_port_capture.sv | 207 ++++++++++++++++++++
 tb/tb_lpc_port_capture.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_port_capture.sv
// lpc_port_capture: passive LPC I/O-write snooper for one port.
// Captured bytes queue in a FIFO and are handed to the uart one at a time.
module lpc_port_capture #(
  parameter logic [15:0] PORT_ADDR       = 16'h03F8,
  parameter int          FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               lad,
  input  logic                     lframe_n,
  input  logic                     uart_busy,
  output logic [7:0]               data,
  output logic                     data_valid,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);

  localparam int N     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;

  typedef enum logic [2:0] {
    L_IDLE,
    L_CYC,
    L_A3,
    L_A2,
    L_A1,
    L_A0,
    L_D0,
    L_D1
  } lpc_st_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_HI,
    S_WAIT_LO
  } snd_st_t;

  lpc_st_t l_st;
  lpc_st_t l_nxt;
  logic [15:0] addr_q;
  logic [15:0] addr_d;
  logic [3:0]  dlo_q;
  logic [3:0]  dlo_d;
  logic        cap_req;
  logic [7:0]  cap_byte;

  snd_st_t s_st;
  snd_st_t s_nxt;
  logic    load;
  logic    pop;

  logic [7:0] mem [DEPTH];
  logic [N:0] wr_ptr;
  logic [N:0] rd_ptr;
  logic       empty;
  logic       full;
  logic       push_ok;
  logic       drop;
  logic [7:0] head;

  // LPC decode: a low LFRAME# always restarts or kills the cycle
  always_comb begin
    l_nxt    = l_st;
    addr_d   = addr_q;
    dlo_d    = dlo_q;
    cap_req  = 1'b0;
    cap_byte = {lad, dlo_q};
    if (!lframe_n) begin
      if (lad == 4'b0000) begin
        l_nxt = L_CYC;
      end else begin
        l_nxt = L_IDLE;
      end
    end else begin
      unique case (l_st)
        L_IDLE: l_nxt = L_IDLE;
        L_CYC: begin
          if (lad == 4'b0010) begin
            l_nxt = L_A3;
          end else begin
            l_nxt = L_IDLE;
          end
        end
        L_A3: begin
          addr_d = {addr_q[11:0], lad};
          l_nxt  = L_A2;
        end
        L_A2: begin
          addr_d = {addr_q[11:0], lad};
          l_nxt  = L_A1;
        end
        L_A1: begin
          addr_d = {addr_q[11:0], lad};
          l_nxt  = L_A0;
        end
        L_A0: begin
          addr_d = {addr_q[11:0], lad};
          l_nxt  = L_D0;
        end
        L_D0: begin
          dlo_d = lad;
          l_nxt = L_D1;
        end
        L_D1: begin
          cap_req = (addr_q == PORT_ADDR);
          l_nxt   = L_IDLE;
        end
        default: l_nxt = L_IDLE;
      endcase
    end
  end

  // LPC decoder state and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      l_st   <= L_IDLE;
      addr_q <= '0;
      dlo_q  <= '0;
    end else begin
      l_st   <= l_nxt;
      addr_q <= addr_d;
      dlo_q  <= dlo_d;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[N] != rd_ptr[N]) &&
                 (wr_ptr[N-1:0] == rd_ptr[N-1:0]);

  // A pop on the same edge frees the slot, so a full push still lands
  assign push_ok = cap_req && (!full || pop);
  assign drop    = cap_req && full && !pop;

  assign head       = mem[rd_ptr[N-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[N-1:0]] <= cap_byte;
    end
  end

  // FIFO pointers and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Send handshake: pulse, wait busy high, wait busy low, then pop
  always_comb begin
    s_nxt = s_st;
    load  = 1'b0;
    pop   = 1'b0;
    unique case (s_st)
      S_IDLE: begin
        if (!empty && !uart_busy) begin
          s_nxt = S_PULSE;
          load  = 1'b1;
        end
      end
      S_PULSE: s_nxt = S_WAIT_HI;
      S_WAIT_HI: begin
        if (uart_busy) begin
          s_nxt = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!uart_busy) begin
          s_nxt = S_IDLE;
          pop   = 1'b1;
        end
      end
      default: s_nxt = S_IDLE;
    endcase
  end

  // Send state; data only changes on a new load so uart sees it stable
  always_ff @(posedge clk) begin
    if (rst) begin
      s_st       <= S_IDLE;
      data       <= '0;
      data_valid <= 1'b0;
    end else begin
      s_st       <= s_nxt;
      data_valid <= load;
      if (load) begin
        data <= head;
      end
    end
  end

endmodule

// File: tb/tb_lpc_port_capture.sv
// tb_lpc_port_capture: directed LPC writes with a queued scoreboard.
// A small uart model answers data_valid with a busy window.
module tb_lpc_port_capture;

  localparam int BUSY_CYC = 12;

  logic       clk;
  logic       rst;
  logic [3:0] lad;
  logic       lframe_n;
  logic       uart_busy;
  logic [7:0] data;
  logic       data_valid;
  logic       overflow;
  logic [4:0] fifo_level;

  logic hold;
  logic busy_m;

  int checks;
  int errors;
  int cyc;
  int dv_count;
  int last_dv_cyc;
  int last_wr_cyc;
  logic [4:0] level_at_wr;
  logic       ovf_at_wr;

  logic [7:0] exp_q [$];

  assign uart_busy = hold | busy_m;

  lpc_port_capture #(
    .PORT_ADDR      (16'h03F8),
    .FIFO_DEPTH_LOG2(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lad       (lad),
    .lframe_n  (lframe_n),
    .uart_busy (uart_busy),
    .data      (data),
    .data_valid(data_valid),
    .overflow  (overflow),
    .fifo_level(fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every data_valid pulse
  initial begin
    logic [7:0] e;
    logic prev_dv;
    prev_dv = 1'b0;
    dv_count = 0;
    last_dv_cyc = 0;
    forever begin
      @(negedge clk);
      if (prev_dv) begin
        chk("dv_width", {31'd0, data_valid}, 32'd0);
      end
      if (data_valid) begin
        dv_count = dv_count + 1;
        last_dv_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL dv_unexpected: got %0h expected none", data);
        end else begin
          e = exp_q.pop_front();
          chk("data", {24'd0, data}, {24'd0, e});
        end
      end
      prev_dv = data_valid;
    end
  end

  // Uart model: busy window after each request, data must hold still
  initial begin
    logic [7:0] held;
    logic ok;
    busy_m = 1'b0;
    forever begin
      @(negedge clk);
      if (data_valid) begin
        busy_m = 1'b1;
        held = data;
        ok = 1'b1;
        repeat (BUSY_CYC) begin
          @(negedge clk);
          if (data !== held) ok = 1'b0;
        end
        busy_m = 1'b0;
        chk("data_stable", {31'd0, ok}, 32'd1);
      end
    end
  end

  task automatic lpc_cycle(input logic [3:0]  ct,
                           input logic [15:0] a,
                           input logic [7:0]  d,
                           input int          abort_at,
                           input bit          rel);
    logic [3:0] nib [8];
    nib = '{4'h0, ct, a[15:12], a[11:8],
            a[7:4], a[3:0], d[3:0], d[7:4]};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        lframe_n = 1'b0;
        lad = 4'h0;
        return;
      end
      lframe_n = (i == 0) ? 1'b0 : 1'b1;
      lad = nib[i];
      if (i == 7 && rel) hold = 1'b0;
    end
    @(negedge clk);
    last_wr_cyc = cyc;
    level_at_wr = fifo_level;
    ovf_at_wr = overflow;
    lframe_n = 1'b1;
    lad = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] d);
    lpc_cycle(4'h2, 16'h03F8, d, -1, 1'b0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy_m &&
          fifo_level == 5'd0 && !data_valid) begin
        done = 1'b1;
      end
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic pulse_rst(input string name);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk({name, "_data"}, {24'd0, data}, 32'd0);
    chk({name, "_dv"}, {31'd0, data_valid}, 32'd0);
    chk({name, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({name, "_level"}, {27'd0, fifo_level}, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    lad = 4'hF;
    lframe_n = 1'b1;
    hold = 1'b0;
    level_at_wr = '0;
    ovf_at_wr = 1'b0;
    last_wr_cyc = 0;
    repeat (2) @(negedge clk);
    pulse_rst("reset");

    // single write of 0x41
    exp_q.push_back(8'h41);
    wr(8'h41);
    chk("t1_level", {27'd0, level_at_wr}, 32'd1);
    chk("t1_latency", last_dv_cyc, last_wr_cyc + 1);
    wait_idle("t1_drain", 200);

    // address and cycle-type filter
    d0 = dv_count;
    lpc_cycle(4'h2, 16'h03F9, 8'h11, -1, 1'b0);
    chk("f_3f9", {27'd0, level_at_wr}, 32'd0);
    lpc_cycle(4'h2, 16'h0080, 8'h22, -1, 1'b0);
    chk("f_080", {27'd0, level_at_wr}, 32'd0);
    lpc_cycle(4'h0, 16'h03F8, 8'h33, -1, 1'b0);
    chk("f_ioread", {27'd0, level_at_wr}, 32'd0);
    lpc_cycle(4'h6, 16'h03F8, 8'h44, -1, 1'b0);
    chk("f_memwr", {27'd0, level_at_wr}, 32'd0);
    repeat (5) @(negedge clk);
    chk("f_no_dv", dv_count, d0);

    // overflow: 18 writes while uart is held busy
    hold = 1'b1;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      wr(8'(i));
    end
    chk("ovf_level", {27'd0, fifo_level}, 32'd16);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    hold = 1'b0;
    wait_idle("ovf_drain", 3000);

    // pointer wrap with concurrent draining
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      wr(8'h80 + 8'(i));
    end
    wait_idle("wrap_drain", 3000);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // abort during A1, then a complete write of 0x5A
    d0 = dv_count;
    exp_q.push_back(8'h5A);
    lpc_cycle(4'h2, 16'h03F8, 8'hC3, 4, 1'b0);
    wr(8'h5A);
    wait_idle("abort_drain", 300);
    chk("abort_count", dv_count, d0 + 1);

    // simultaneous push and pop while full
    pulse_rst("rst2");
    exp_q.push_back(8'hA0);
    wr(8'hA0);
    for (int i = 0; i < 50 && !busy_m; i++) @(negedge clk);
    hold = 1'b1;
    for (int i = 1; i < 16; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      wr(8'hA0 + 8'(i));
    end
    chk("pp_full", {27'd0, fifo_level}, 32'd16);
    exp_q.push_back(8'hB0);
    lpc_cycle(4'h2, 16'h03F8, 8'hB0, -1, 1'b1);
    chk("pp_level", {27'd0, level_at_wr}, 32'd16);
    chk("pp_ovf", {31'd0, ovf_at_wr}, 32'd0);
    wait_idle("pp_drain", 3000);
    chk("pp_ovf_end", {31'd0, overflow}, 32'd0);

    // reset while busy with three bytes queued
    hold = 1'b1;
    wr(8'hE1);
    wr(8'hE2);
    wr(8'hE3);
    chk("rm_level", {27'd0, fifo_level}, 32'd3);
    pulse_rst("rst3");
    exp_q.push_back(8'h77);
    d0 = dv_count;
    wr(8'h77);
    repeat (20) @(negedge clk);
    chk("rm_held", dv_count, d0);
    chk("rm_level2", {27'd0, fifo_level}, 32'd1);
    hold = 1'b0;
    wait_idle("rm_drain", 300);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
